// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared types and codes for the data-side sram-like bridge: FSM states,
// load-width and transfer-size encodings, and the request-size helper.
package dmem_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } bridgeState_e;

    localparam logic [3:0] RW_BYTE = 4'b0001;
    localparam logic [3:0] RW_HALF = 4'b0011;
    localparam logic [3:0] RW_WORD = 4'b1111;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Everything about a request except its address, whose width is a parameter.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  width;
        logic        sign;
    } dmemReq_t;

    // Stores size from the byte-enable pattern, loads from the width code; odd codes fall back to word.
    function automatic logic [1:0] reqSize(input logic [3:0] wmask, input logic [3:0] width);
        logic [1:0] size;
        size = SIZE_WORD;
        if (|wmask) begin
            case (wmask)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
                4'b0011, 4'b1100:                   size = SIZE_HALF;
                default:                            size = SIZE_WORD;
            endcase
        end else begin
            case (width)
                RW_BYTE: size = SIZE_BYTE;
                RW_HALF: size = SIZE_HALF;
                default: size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/dmem_sram_like_bridge_load_align.sv
// Picks the addressed byte/halfword lane out of a raw read word and
// sign- or zero-extends it to 32 bits; full words pass through.
module dmem_sram_like_bridge_load_align
    import dmem_sram_like_bridge_pkg::*;
(
    input  logic [31:0] rawData,
    input  logic [1:0]  addrLo,
    input  logic [3:0]  width,
    input  logic        isSigned,
    output logic [31:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    assign byteLane = rawData[{addrLo, 3'b000} +: 8];
    assign halfLane = addrLo[1] ? rawData[31:16] : rawData[15:0];

    always_comb begin
        case (width)
            RW_BYTE: result = {{24{isSigned & byteLane[7]}}, byteLane};
            RW_HALF: result = {{16{isSigned & halfLane[15]}}, halfLane};
            default: result = rawData;
        endcase
    end

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// M-stage data-memory bridge: turns each access into one sram-like
// req/addr_ok/data_ok transaction, stalls the pipeline meanwhile, aligns loads.
module dmem_sram_like_bridge
    import dmem_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter bit MASK_KSEG  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_sram_enM,
    input  logic [3:0]            memwriteM,
    input  logic [3:0]            memReadWidthM,
    input  logic                  memLoadIsSignM,
    input  logic [ADDR_WIDTH-1:0] addrM,
    input  logic [31:0]           wdataM,
    input  logic                  exceptM,
    input  logic                  stall_otherM,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,
    output logic                  d_stall,
    output logic [31:0]           rdataM
);

    bridgeState_e          state, nextState;
    logic                  start, useLive;
    dmemReq_t              liveReq, heldReq, reqView;
    logic [ADDR_WIDTH-1:0] liveAddr, heldAddr, addrView;
    logic [31:0]           rdataQ;
    logic [1:0]            ldAddrLo;
    logic [3:0]            ldWidth;
    logic                  ldSign;

    // Qualified by rst so nothing is requested while reset is held low.
    assign start = data_sram_enM & ~exceptM & rst;

    always_comb begin
        liveAddr = addrM;
        if (MASK_KSEG && addrM[ADDR_WIDTH-1 -: 2] == 2'b10)
            liveAddr = {3'b000, addrM[ADDR_WIDTH-4:0]};
        liveReq.wr    = |memwriteM;
        liveReq.size  = reqSize(memwriteM, memReadWidthM);
        liveReq.wdata = wdataM;
        liveReq.width = memReadWidthM;
        liveReq.sign  = memLoadIsSignM;
    end

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Width/sign/address are kept even when addr_ok arrives at once: the load aligner needs them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            heldReq  <= '0;
            heldAddr <= '0;
        end else if (state == IDLE && start) begin
            heldReq  <= liveReq;
            heldAddr <= liveAddr;
        end
    end

    // Stores never touch the load result, so rdataM holds the last load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdataQ   <= '0;
            ldAddrLo <= '0;
            ldWidth  <= '0;
            ldSign   <= 1'b0;
        end else if (state == WAIT_DATA && data_data_ok && !heldReq.wr) begin
            rdataQ   <= data_rdata;
            ldAddrLo <= heldAddr[1:0];
            ldWidth  <= heldReq.width;
            ldSign   <= heldReq.sign;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        nextState = state;
        data_req  = 1'b0;
        d_stall   = 1'b0;
        useLive   = 1'b0;
        case (state)
            IDLE: begin
                data_req = start;
                d_stall  = start;
                useLive  = 1'b1;
                if (start) nextState = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
            end
            WAIT_ADDR: begin
                data_req = 1'b1;
                d_stall  = 1'b1;
                if (data_addr_ok) nextState = WAIT_DATA;
            end
            WAIT_DATA: begin
                d_stall = 1'b1;
                if (data_data_ok) nextState = DONE;
            end
            DONE: begin
                if (!stall_otherM) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign reqView    = useLive ? liveReq : heldReq;
    assign addrView   = useLive ? liveAddr : heldAddr;
    assign data_wr    = data_req & reqView.wr;
    assign data_size  = data_req ? reqView.size : 2'd0;
    assign data_addr  = data_req ? addrView : '0;
    assign data_wdata = data_req ? reqView.wdata : 32'd0;

    dmem_sram_like_bridge_load_align u_loadAlign (
        .rawData (rdataQ),
        .addrLo  (ldAddrLo),
        .width   (ldWidth),
        .isSigned(ldSign),
        .result  (rdataM)
    );

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
// Bench for dmem_sram_like_bridge: the bench plays the interconnect with chosen
// addr_ok/data_ok delays and checks every cycle against a transaction-level model.
module tb_dmem_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_enM, memLoadIsSignM, exceptM, stall_otherM;
    logic [3:0]  memwriteM, memReadWidthM;
    logic [31:0] addrM, wdataM;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, d_stall;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, rdataM;

    int nChecks = 0;
    int nPass   = 0;

    bit          checkEn = 1'b0;
    logic        expReq = 1'b0, expStall = 1'b0, expWr = 1'b0;
    logic [1:0]  expSize = 2'd0;
    logic [31:0] expAddr = '0, expWdata = '0, expRdata = '0;
    logic [31:0] lastRd = '0;

    always #5 clk = ~clk;

    dmem_sram_like_bridge #(.ADDR_WIDTH(32), .MASK_KSEG(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_sram_enM (data_sram_enM),
        .memwriteM     (memwriteM),
        .memReadWidthM (memReadWidthM),
        .memLoadIsSignM(memLoadIsSignM),
        .addrM         (addrM),
        .wdataM        (wdataM),
        .exceptM       (exceptM),
        .stall_otherM  (stall_otherM),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .rdataM        (rdataM)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: kseg0/1 addresses lose their top three bits.
    function automatic logic [31:0] mapAddr(input logic [31:0] a);
        return (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
    endfunction

    // Model: transfer size follows the number of bytes touched.
    function automatic logic [1:0] sizeOf(input logic [3:0] lanes);
        case ($countones(lanes))
            1:       return 2'd0;
            2:       return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    // Model: shift the addressed lane down, then mask or fill the upper bits.
    function automatic logic [31:0] loadModel(input logic [31:0] raw, input logic [31:0] addr,
                                              input logic [3:0] width, input bit sgn);
        logic [31:0] s;
        s = raw >> (8 * int'(addr[1:0]));
        if (width == 4'b0001) return (sgn && s[7])  ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
        if (width == 4'b0011) return (sgn && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
        return raw;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            check("data_req", 32'(data_req), 32'(expReq));
            check("d_stall",  32'(d_stall),  32'(expStall));
            check("rdataM",   rdataM,        expRdata);
            if (expReq) begin
                check("data_wr",    32'(data_wr),   32'(expWr));
                check("data_size",  32'(data_size), 32'(expSize));
                check("data_addr",  data_addr,      expAddr);
                check("data_wdata", data_wdata,     expWdata);
            end
        end
    end

    task automatic scrambleM();
        data_sram_enM  = 1'($urandom);
        exceptM        = 1'($urandom);
        memwriteM      = 4'($urandom);
        memReadWidthM  = 4'($urandom);
        memLoadIsSignM = 1'($urandom);
        addrM          = $urandom;
        wdataM         = $urandom;
    endtask

    // One access: addr_ok on cycle a, data_ok a+d cycles in, then s extra DONE cycles under stall_otherM.
    task automatic doAccess(input bit isStore, input logic [3:0] lanes, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] raw,
                            input int a, input int d, input int s,
                            input bit pinEn, input logic [31:0] pinAddr);
        logic [31:0] newRd;
        newRd = isStore ? lastRd : loadModel(raw, addr, lanes, sgn);
        for (int c = 0; c <= a + d + 1 + s; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                data_sram_enM  = 1'b1;
                exceptM        = 1'b0;
                memwriteM      = isStore ? lanes : 4'b0000;
                memReadWidthM  = isStore ? 4'($urandom) : lanes;
                memLoadIsSignM = sgn;
                addrM          = addr;
                wdataM         = wdata;
            end else begin
                scrambleM();
            end
            if (c > a + d) stall_otherM = (c <= a + d + s);
            else           stall_otherM = 1'($urandom);
            data_addr_ok = (c == a);
            if (c == a + d)            data_data_ok = 1'b1;
            else if (c > a && c < a + d) data_data_ok = 1'b0;
            else                       data_data_ok = 1'($urandom);
            data_rdata = (c == a + d) ? raw : $urandom;
            expReq   = (c <= a);
            expStall = (c <= a + d);
            expWr    = isStore;
            expSize  = sizeOf(lanes);
            expAddr  = mapAddr(addr);
            expWdata = wdata;
            expRdata = (c <= a + d) ? lastRd : newRd;
            if (c == 0 && pinEn) begin
                #1 check("pin_data_addr", data_addr, pinAddr);
            end
        end
        lastRd = newRd;
    endtask

    task automatic idleCycle(input logic en, input logic exc);
        @(posedge clk); #1;
        scrambleM();
        data_sram_enM = en;
        exceptM       = exc;
        stall_otherM  = 1'($urandom);
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'($urandom);
        data_rdata    = $urandom;
        expReq   = 1'b0;
        expStall = 1'b0;
        expRdata = lastRd;
    endtask

    logic [3:0] storeMasks [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [3:0] loadWidths [3] = '{4'b0001, 4'b0011, 4'b1111};

    initial begin
        rst = 1'b0;
        data_sram_enM = 0; memwriteM = 0; memReadWidthM = 0; memLoadIsSignM = 0;
        addrM = 0; wdataM = 0; exceptM = 0; stall_otherM = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        checkEn = 1'b1;

        // Reset: outputs stay low even with an access presented.
        @(posedge clk); #1;
        data_sram_enM = 1'b1;
        @(posedge clk); #1;
        check("reset_req", 32'(data_req), 32'd0);
        data_sram_enM = 1'b0;
        rst = 1'b1;

        // Directed loads with hand-computed results.
        doAccess(0, 4'b1111, 0, 32'h8000_0010, 32'h0, 32'h1234_5678, 0, 1, 0, 1, 32'h0000_0010);
        check("lw_rdataM", rdataM, 32'h1234_5678);
        doAccess(0, 4'b0001, 1, 32'h0000_0203, 32'h0, 32'h80AA_BBCC, 0, 1, 0, 0, 32'h0);
        check("lb_rdataM", rdataM, 32'hFFFF_FF80);
        doAccess(0, 4'b0001, 0, 32'h0000_0203, 32'h0, 32'h80AA_BBCC, 1, 2, 0, 0, 32'h0);
        check("lbu_rdataM", rdataM, 32'h0000_0080);
        doAccess(0, 4'b0011, 1, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 0, 1, 0, 0, 32'h0);
        check("lh_rdataM", rdataM, 32'hFFFF_8001);
        doAccess(0, 4'b0011, 0, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 0, 1, 0, 0, 32'h0);
        check("lhu_rdataM", rdataM, 32'h0000_8001);

        // Byte store with addr_ok three cycles late; load result untouched.
        doAccess(1, 4'b0100, 0, 32'h0000_0102, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 3, 1, 0, 1, 32'h0000_0102);
        check("sb_keeps_rdataM", rdataM, 32'h0000_8001);

        // Load finishing under a two-cycle foreign stall.
        doAccess(0, 4'b1111, 0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 1, 2, 0, 32'h0);
        check("stall_other_rdataM", rdataM, 32'hCAFE_F00D);

        // Exception suppresses a new request.
        idleCycle(1'b1, 1'b1);
        #1 check("except_req", 32'(data_req), 32'd0);
        check("except_stall", 32'(d_stall), 32'd0);

        // Reset while waiting for data.
        @(posedge clk); #1;
        data_sram_enM = 1; exceptM = 0; memwriteM = 0; memReadWidthM = 4'b1111;
        memLoadIsSignM = 0; addrM = 32'h0000_0040; wdataM = 0; stall_otherM = 0;
        data_addr_ok = 1; data_data_ok = 0;
        expReq = 1; expStall = 1; expWr = 0; expSize = 2; expAddr = 32'h40; expWdata = 0;
        expRdata = lastRd;
        @(posedge clk); #1;
        data_addr_ok = 0;
        expReq = 0; expStall = 1;
        #1 rst = 1'b0;
        expStall = 0; expRdata = 0; lastRd = 0;
        #1 check("rst_mid_stall", 32'(d_stall), 32'd0);
        check("rst_mid_rdataM", rdataM, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_sram_enM = 0;
        rst = 1'b1;

        // Randomized traffic.
        repeat (200) begin
            bit          isStore;
            logic [3:0]  lanes;
            logic [31:0] addr;
            logic [1:0]  lo;
            if ($urandom_range(0, 2) == 0) begin
                logic en;
                en = 1'($urandom);
                idleCycle(en, en ? 1'b1 : 1'($urandom));
            end
            isStore = ($urandom_range(0, 2) == 0);
            if (isStore) begin
                lanes = storeMasks[$urandom_range(0, 6)];
                case (lanes)
                    4'b0010: lo = 2'd1;
                    4'b0100: lo = 2'd2;
                    4'b1000: lo = 2'd3;
                    4'b1100: lo = 2'd2;
                    default: lo = 2'd0;
                endcase
            end else begin
                lanes = loadWidths[$urandom_range(0, 2)];
                if (lanes == 4'b0001)      lo = 2'($urandom);
                else if (lanes == 4'b0011) lo = {1'($urandom), 1'b0};
                else                       lo = 2'd0;
            end
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[31:30] = 2'b10;
            addr[1:0] = lo;
            doAccess(isStore, lanes, 1'($urandom), addr, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2), 0, 32'h0);
        end

        @(posedge clk); #1;
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
